// File: rtl/codes_pdec_2to4_queue.sv
// codes_pdec_2to4_queue: 2-entry queue that decodes buffered binary codes to one-hot words.
// Optional macro CODES_PDEC_ZERO_EN adds in_zero; an entry stored with it set decodes to all-zero.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   in_, in_val       incoming code and its valid; in_rdy = room in the queue
//   out, out_val      one-hot decode of the head entry (zero when empty); out_rdy = consumer accepts
//   count             current occupancy 0..2
//   in_zero           (CODES_PDEC_ZERO_EN only) marks the encoder's "no request" case
module codes_pdec_2to4_queue #(
    parameter int NBITS = 2,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NBITS-1:0]    in_,
    input  logic                in_val,
    output logic                in_rdy,
    output logic [2**NBITS-1:0] out,
    output logic                out_val,
    input  logic                out_rdy,
`ifdef CODES_PDEC_ZERO_EN
    input  logic                in_zero,
`endif
    output logic [1:0]          count
);
`ifdef CODES_PDEC_ZERO_EN
    localparam int EW = NBITS + 1;
`else
    localparam int EW = NBITS;
`endif
    logic [EW-1:0] mem_q [2];
    logic [EW-1:0] in_entry, head_entry;
    logic          head_q, head_d, tail_q, tail_d;
    logic [1:0]    count_q, count_d;
    logic          enq, deq, zero;
`ifdef CODES_PDEC_ZERO_EN
    assign in_entry = {in_zero, in_};
    assign zero     = head_entry[NBITS];
`else
    assign in_entry = in_;
    assign zero     = 1'b0;
`endif
    assign in_rdy     = count_q < 2'(DEPTH);
    assign out_val    = count_q != 2'd0;
    assign count      = count_q;
    assign enq        = in_val && in_rdy;
    assign deq        = out_val && out_rdy;
    assign head_entry = mem_q[head_q];
    assign out        = (out_val && !zero) ? (2**NBITS)'(1) << head_entry[NBITS-1:0] : '0;
    always_comb begin
        head_d  = deq ? ~head_q : head_q;
        tail_d  = enq ? ~tail_q : tail_q;
        count_d = count_q + 2'(enq) - 2'(deq);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    // Storage needs no reset: it is only observed through out, which is gated by count.
    always_ff @(posedge clk) begin
        if (!reset && enq) mem_q[tail_q] <= in_entry;
    end
endmodule

// File: tb/tb_codes_pdec_2to4_queue.sv
// tb_codes_pdec_2to4_queue: directed vector table plus randomized run against a queue model.
module tb_codes_pdec_2to4_queue;
    logic       clk = 1'b0;
    logic       reset, in_val, out_rdy, in_rdy, out_val, zero;
    logic [1:0] din, count;
    logic [3:0] out;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    codes_pdec_2to4_queue dut (
        .clk(clk), .reset(reset), .in_(din), .in_val(in_val), .in_rdy(in_rdy),
        .out(out), .out_val(out_val), .out_rdy(out_rdy),
`ifdef CODES_PDEC_ZERO_EN
        .in_zero(zero),
`endif
        .count(count)
    );

    typedef struct {
        string      name;
        logic       rst, val, ordy, z;
        logic [1:0] code;
        logic [3:0] e_out;
        logic       e_val, e_rdy;
        logic [1:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(string n, logic r, logic [1:0] c, logic v, logic o, logic z,
                                logic [3:0] eo, logic ev, logic er, logic [1:0] ec);
        vec_t t;
        t.name = n; t.rst = r; t.code = c; t.val = v; t.ordy = o; t.z = z;
        t.e_out = eo; t.e_val = ev; t.e_rdy = er; t.e_cnt = ec;
        vecs.push_back(t);
    endfunction

    task automatic check(string n, logic [3:0] eo, logic ev, logic er, logic [1:0] ec);
        n_checks++;
        if ({out, out_val, in_rdy, count} !== {eo, ev, er, ec}) begin
            n_fail++;
            $display("FAIL %s: got out=%b val=%b rdy=%b cnt=%0d, want out=%b val=%b rdy=%b cnt=%0d",
                     n, out, out_val, in_rdy, count, eo, ev, er, ec);
        end
    endtask

    // Model: entries are {zero, code}; expected outputs follow directly from occupancy and head.
    int model[$];

    initial begin
        add("reset",      1, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
        add("idle1",      0, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
        add("idle2",      0, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
        add("idle3",      0, 0, 0, 0, 0, 4'b0000, 0, 1, 0);
        add("code0",      0, 0, 1, 1, 0, 4'b0001, 1, 1, 1);
        add("code1",      0, 1, 1, 1, 0, 4'b0010, 1, 1, 1);
        add("code2",      0, 2, 1, 1, 0, 4'b0100, 1, 1, 1);
        add("code3",      0, 3, 1, 1, 0, 4'b1000, 1, 1, 1);
        add("drain",      0, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
        add("bp_enq3",    0, 3, 1, 0, 0, 4'b1000, 1, 1, 1);
        add("bp_enq1",    0, 1, 1, 0, 0, 4'b1000, 1, 0, 2);
        add("bp_full",    0, 2, 1, 0, 0, 4'b1000, 1, 0, 2);
        add("bp_deq1",    0, 0, 0, 1, 0, 4'b0010, 1, 1, 1);
        add("bp_deq2",    0, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
        add("sim_load",   0, 2, 1, 0, 0, 4'b0100, 1, 1, 1);
        add("sim_both",   0, 0, 1, 1, 0, 4'b0001, 1, 1, 1);
        add("sim_drain",  0, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
        add("mid_load1",  0, 1, 1, 0, 0, 4'b0010, 1, 1, 1);
        add("mid_load2",  0, 2, 1, 0, 0, 4'b0010, 1, 0, 2);
        add("mid_reset",  1, 3, 1, 1, 0, 4'b0000, 0, 1, 0);
        add("post_enq3",  0, 3, 1, 0, 0, 4'b1000, 1, 1, 1);
        add("post_drain", 0, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
`ifdef CODES_PDEC_ZERO_EN
        add("zero_enq",   0, 0, 1, 0, 1, 4'b0000, 1, 1, 1);
        add("zero_then0", 0, 0, 1, 1, 0, 4'b0001, 1, 1, 1);
        add("zero_drain", 0, 0, 0, 1, 0, 4'b0000, 0, 1, 0);
`endif
        foreach (vecs[i]) begin
            reset = vecs[i].rst; din = vecs[i].code; in_val = vecs[i].val;
            out_rdy = vecs[i].ordy; zero = vecs[i].z;
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].e_out, vecs[i].e_val, vecs[i].e_rdy, vecs[i].e_cnt);
        end

        reset = 1'b0;
        for (int cyc = 0; cyc < 500; cyc++) begin
            bit acc, dq;
            int h;
            logic [3:0] eo;
            din     = 2'($urandom_range(0, 3));
            in_val  = $urandom_range(0, 9) < 7;
            out_rdy = $urandom_range(0, 9) < 6;
`ifdef CODES_PDEC_ZERO_EN
            zero    = $urandom_range(0, 7) == 0;
`else
            zero    = 1'b0;
`endif
            acc = in_val && model.size() < 2;
            dq  = out_rdy && model.size() > 0;
            @(posedge clk); #1;
            if (dq) void'(model.pop_front());
            if (acc) model.push_back(zero ? 4 + int'(din) : int'(din));
            eo = 4'b0000;
            if (model.size() > 0) begin
                h = model[0];
                if (h < 4) eo[h] = 1'b1;
            end
            check("random", eo, model.size() > 0, model.size() < 2, 2'(model.size()));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
